// File: rtl/path_node_sequencer_if.sv
// rtl/path_node_sequencer_if.sv - route entry load channel between route source and sequencer
interface path_node_sequencer_if #(
  parameter int POS_W = 5
) ();
  logic             load_valid;
  logic             load_ready;
  logic [POS_W-1:0] load_pos;
  logic [1:0]       load_turn;
  logic             load_last;

  modport master (
    output load_valid,
    output load_pos,
    output load_turn,
    output load_last,
    input  load_ready
  );

  modport slave (
    input  load_valid,
    input  load_pos,
    input  load_turn,
    input  load_last,
    output load_ready
  );
endinterface

// File: rtl/path_node_sequencer.sv
// rtl/path_node_sequencer.sv - steps the line follower through a preloaded node route
module path_node_sequencer #(
  parameter int MAX_NODES = 32,
  parameter int POS_W     = 5,
  parameter int MIN_GAP   = 3125
) (
  input  logic                 clk_3125KHz,
  input  logic                 rst,
  path_node_sequencer_if.slave ld,
  input  logic                 start,
  input  logic                 clear,
  input  logic                 node_changed,
  input  logic                 EU_FAULT_FLAG,
  output logic [POS_W-1:0]     realtime_pos,
  output logic [1:0]           turn_flag,
  output logic                 end_path,
  output logic                 run_en,
  output logic [5:0]           path_len,
  output logic [4:0]           node_idx,
  output logic                 load_err
);
  localparam int               GAP_W     = $clog2(MIN_GAP + 1);
  localparam logic [GAP_W-1:0] GAP_MAX   = GAP_W'(MIN_GAP);
  localparam logic [4:0]       LAST_SLOT = 5'(MAX_NODES - 1);

  typedef enum logic [2:0] {IDLE, LOAD, READY, RUN, HOLD, DONE} state_t;

  state_t           state;
  logic [POS_W+1:0] mem [MAX_NODES];
  logic [4:0]       wr_ptr;
  logic [GAP_W-1:0] gap_cnt;
  logic             start_q;

  logic             load_fire;
  logic             last_entry;
  logic             gap_ok;
  logic             at_last;
  logic [4:0]       next_idx;
  logic [POS_W+1:0] entry0;

  assign load_fire  = ld.load_valid && ld.load_ready;
  // A full memory forces the current entry to close the route.
  assign last_entry = ld.load_last || (wr_ptr == LAST_SLOT);
  assign gap_ok     = (gap_cnt == GAP_MAX);
  assign at_last    = ({1'b0, node_idx} == (path_len - 6'd1));
  assign next_idx   = node_idx + 5'd1;
  // A one-entry route writes slot 0 on the same edge it is presented, so forward it.
  assign entry0     = (wr_ptr == 5'd0) ? {ld.load_pos, ld.load_turn} : mem[0];

  // Route memory write port; contents are not reset and are rewritten on each load.
  always_ff @(posedge clk_3125KHz) begin
    if (load_fire && !clear) begin
      mem[wr_ptr] <= {ld.load_pos, ld.load_turn};
    end
  end

  // Sequencer FSM with all outputs registered.
  always_ff @(posedge clk_3125KHz or posedge rst) begin
    if (rst) begin
      state         <= IDLE;
      ld.load_ready <= 1'b1;
      wr_ptr        <= '0;
      gap_cnt       <= GAP_MAX;
      start_q       <= 1'b0;
      realtime_pos  <= '0;
      turn_flag     <= '0;
      end_path      <= 1'b0;
      run_en        <= 1'b0;
      path_len      <= '0;
      node_idx      <= '0;
      load_err      <= 1'b0;
    end else begin
      start_q <= start;
      if (clear) begin
        state         <= IDLE;
        ld.load_ready <= 1'b1;
        wr_ptr        <= '0;
        gap_cnt       <= GAP_MAX;
        realtime_pos  <= '0;
        turn_flag     <= '0;
        end_path      <= 1'b0;
        run_en        <= 1'b0;
        path_len      <= '0;
        node_idx      <= '0;
        load_err      <= 1'b0;
      end else begin
        case (state)
          IDLE, LOAD: begin
            gap_cnt <= GAP_MAX;
            if (load_fire) begin
              if (last_entry) begin
                path_len                  <= 6'(wr_ptr) + 6'd1;
                wr_ptr                    <= '0;
                ld.load_ready             <= 1'b0;
                load_err                  <= !ld.load_last;
                {realtime_pos, turn_flag} <= entry0;
                state                     <= READY;
              end else begin
                wr_ptr <= wr_ptr + 5'd1;
                state  <= LOAD;
              end
            end
          end
          READY: begin
            {realtime_pos, turn_flag} <= mem[0];
            if (start && !start_q) begin
              node_idx <= '0;
              run_en   <= 1'b1;
              state    <= RUN;
            end
          end
          RUN: begin
            if (EU_FAULT_FLAG) begin
              // Fault beats a coincident node pulse; counter and index freeze.
              run_en <= 1'b0;
              state  <= HOLD;
            end else if (node_changed && gap_ok) begin
              gap_cnt <= '0;
              if (at_last) begin
                end_path <= 1'b1;
                run_en   <= 1'b0;
                state    <= DONE;
              end else begin
                node_idx                  <= next_idx;
                {realtime_pos, turn_flag} <= mem[next_idx];
              end
            end else if (!gap_ok) begin
              gap_cnt <= gap_cnt + 1'b1;
            end
          end
          HOLD: begin
            if (!EU_FAULT_FLAG) begin
              run_en <= 1'b1;
              state  <= RUN;
            end
          end
          DONE: begin
            end_path <= 1'b1;
            run_en   <= 1'b0;
          end
          default: state <= IDLE;
        endcase
      end
    end
  end
endmodule
